seg_scan_receiver: RTL and testbench

- Receiving end of the multiplexed seven-segment display interface driven by the top-level bottling controller: 7 segment lines plus 4 digit-select lines.
- Samples the time-multiplexed scan and reconstructs the four displayed BCD digits into a 16-bit word with the same nibble layout as the counter bus.
- Used as an on-board monitor and as a scoreboard tap in the display-path benches.

---
 rtl/seg_scan_receiver.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_receiver.sv
// rtl/seg_scan_receiver.sv - samples a multiplexed 7-segment scan and rebuilds the four BCD digits
// Optional watchdog: define SCAN_TIMEOUT_EN.
module seg_scan_receiver #(
    parameter int STABLE_CYCLES  = 4,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_in,
    output logic [15:0] value,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        dec_err,
    output logic        stale
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_Q = 8'(STABLE_CYCLES);

    state_t      state;
    logic [6:0]  seg_s1, seg_s2;
    logic [3:0]  dig_s1, dig_s2;
    logic [6:0]  seg_p;
    logic [3:0]  dig_p;
    logic [6:0]  seg_q;
    logic [3:0]  dig_q;
    logic [7:0]  cnt;
    logic [3:0]  seen;
    logic [3:0]  seen_next;
    logic        dig_onehot;
    logic [1:0]  dig_idx;
    logic        dec_hit;
    logic [3:0]  dec_val;
    logic        accept;

    always_comb begin
        seg_p = (SEG_ACTIVE_LOW != 0) ? ~seg_s2 : seg_s2;
        dig_p = (DIG_ACTIVE_LOW != 0) ? ~dig_s2 : dig_s2;
    end

    // The FSM judges the registered pair (seg_q, dig_q) together with its run length in cnt.
    always_comb begin
        dig_onehot = 1'b1;
        dig_idx    = 2'd0;
        case (dig_q)
            4'b0001: dig_idx = 2'd0;
            4'b0010: dig_idx = 2'd1;
            4'b0100: dig_idx = 2'd2;
            4'b1000: dig_idx = 2'd3;
            default: dig_onehot = 1'b0;
        endcase
    end

    always_comb begin
        dec_hit = 1'b1;
        dec_val = 4'd0;
        case (seg_q)
            7'h3F: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5B: dec_val = 4'd2;
            7'h4F: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6D: dec_val = 4'd5;
            7'h7D: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7F: dec_val = 4'd8;
            7'h6F: dec_val = 4'd9;
            default: dec_hit = 1'b0;
        endcase
    end

    always_comb begin
        accept    = (state == SETTLE) && dig_onehot && (cnt == STABLE_Q);
        seen_next = seen | (4'b0001 << dig_idx);
    end

`ifdef SCAN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd;
`else
    // Watchdog not built: TIMEOUT_CYCLES has no effect on the output.
    assign stale = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_s1      <= '0;
            seg_s2      <= '0;
            dig_s1      <= '0;
            dig_s2      <= '0;
            seg_q       <= '0;
            dig_q       <= '0;
            cnt         <= '0;
            seen        <= '0;
            state       <= IDLE;
            value       <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            dec_err     <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
            wd          <= '0;
            stale       <= 1'b0;
`endif
        end else begin
            seg_s1     <= seg_in;
            seg_s2     <= seg_s1;
            dig_s1     <= dig_in;
            dig_s2     <= dig_s1;
            frame_done <= 1'b0;

            if ({seg_p, dig_p} != {seg_q, dig_q}) begin
                seg_q <= seg_p;
                dig_q <= dig_p;
                cnt   <= 8'd1;
            end else if (cnt != STABLE_Q) begin
                cnt <= cnt + 8'd1;
            end

`ifdef SCAN_TIMEOUT_EN
            if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd          <= WD_W'(TIMEOUT_CYCLES);
                stale       <= 1'b1;
                digit_valid <= '0;
                seen        <= '0;
            end else if (wd != WD_W'(TIMEOUT_CYCLES)) begin
                wd <= wd + 1'b1;
            end
            if (accept) begin
                wd    <= '0;
                stale <= 1'b0;
            end
`endif

            case (state)
                IDLE: begin
                    if (dig_onehot)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (!dig_onehot)
                        state <= IDLE;
                    else if (accept)
                        state <= HOLD;
                end
                HOLD: begin
                    // A fresh pattern always shows up as a run length of one.
                    if (cnt == 8'd1)
                        state <= dig_onehot ? SETTLE : IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                if (dec_hit) begin
                    value[{dig_idx, 2'b00} +: 4] <= dec_val;
                    digit_valid[dig_idx]         <= 1'b1;
                    if (seen_next == 4'hF) begin
                        frame_done <= 1'b1;
                        seen       <= '0;
                    end else begin
                        seen <= seen_next;
                    end
                end else begin
                    dec_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_receiver.sv
// tb/tb_seg_scan_receiver.sv - scoreboard bench for seg_scan_receiver
// Timeout scenario runs only when SCAN_TIMEOUT_EN is defined.
module tb_seg_scan_receiver;

    localparam int STABLE = 4;
    localparam int TMO    = 100;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  seg_in;
    logic [3:0]  dig_in;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        dec_err;
    logic        stale;

    seg_scan_receiver #(
        .STABLE_CYCLES (STABLE),
        .DIG_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(0),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .seg_in     (seg_in),
        .dig_in     (dig_in),
        .value      (value),
        .digit_valid(digit_valid),
        .frame_done (frame_done),
        .dec_err    (dec_err),
        .stale      (stale)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [15:0] value;
        logic [3:0]  dv;
        logic        fd;
        logic        derr;
        logic        stale;
    } ev_t;

    ev_t         sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] m_value;
    logic [3:0]  m_dv, m_seen;
    logic        m_derr, m_stale;
    logic [10:0] m_prev;
    int          m_acc_cyc;
    logic [21:0] last_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic ref_decode(input logic [6:0] s, output logic hit, output logic [3:0] v);
        hit = 1'b1;
        v   = 4'd0;
        case (s)
            7'h3F: v = 4'd0;  7'h06: v = 4'd1;  7'h5B: v = 4'd2;  7'h4F: v = 4'd3;
            7'h66: v = 4'd4;  7'h6D: v = 4'd5;  7'h7D: v = 4'd6;  7'h07: v = 4'd7;
            7'h7F: v = 4'd8;  7'h6F: v = 4'd9;
            default: hit = 1'b0;
        endcase
    endtask

    task automatic push_ev(input int at, input logic fd);
        ev_t e;
        e.at = at; e.value = m_value; e.dv = m_dv; e.fd = fd; e.derr = m_derr; e.stale = m_stale;
        sb.push_back(e);
    endtask

    task automatic predict(input logic [3:0] dig_raw, input logic [6:0] seg, input int hold, input int e);
        logic [3:0]  d;
        logic [10:0] pat;
        logic [21:0] old_t;
        logic        hit, fd;
        logic [3:0]  v;
        int          k;
        d   = ~dig_raw;
        pat = {seg, d};
        if (hold >= STABLE && $onehot(d) && pat != m_prev) begin
            old_t = {m_value, m_dv, m_derr, m_stale};
            k = 0;
            for (int i = 0; i < 4; i++) if (d[i]) k = i;
            m_acc_cyc = e + 3 + STABLE;
            m_stale   = 1'b0;
            fd        = 1'b0;
            ref_decode(seg, hit, v);
            if (hit) begin
                m_value[4*k +: 4] = v;
                m_dv[k]   = 1'b1;
                m_seen[k] = 1'b1;
                if (m_seen == 4'hF) begin
                    fd     = 1'b1;
                    m_seen = 4'h0;
                end
            end else begin
                m_derr = 1'b1;
            end
            if ({m_value, m_dv, m_derr, m_stale} != old_t || fd)
                push_ev(m_acc_cyc, fd);
        end
        m_prev = pat;
    endtask

    task automatic monitor();
        logic [21:0] t;
        ev_t         e;
        t = {value, digit_valid, dec_err, stale};
        if (t != last_t || frame_done) begin
            if (sb.size() == 0) begin
                check("spurious_update", 32'({frame_done, t}), 32'({1'b0, last_t}));
            end else begin
                e = sb.pop_front();
                check("update_cycle", 32'(cyc), 32'(e.at));
                check("value", 32'(value), 32'(e.value));
                check("digit_valid", 32'(digit_valid), 32'(e.dv));
                check("frame_done", 32'(frame_done), 32'(e.fd));
                check("dec_err", 32'(dec_err), 32'(e.derr));
                check("stale", 32'(stale), 32'(e.stale));
            end
        end
        last_t = t;
    endtask

    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            monitor();
            if (i == 0) begin
                dig_in = d;
                seg_in = s;
                predict(d, s, hold, cyc);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST    = 1'b1;
        dig_in = 4'hF;
        seg_in = 7'h00;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_value", 32'(value), 32'h0);
        check("rst_digit_valid", 32'(digit_valid), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_dec_err", 32'(dec_err), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);
        RST = 1'b0;
        sb.delete();
        m_value = '0; m_dv = '0; m_seen = '0; m_derr = 1'b0; m_stale = 1'b0;
        m_prev = '0; m_acc_cyc = 0; last_t = '0;
    endtask

    initial begin
        RST    = 1'b1;
        dig_in = 4'hF;
        seg_in = 7'h00;
        do_reset();

        // single digit 3 on digit 0
        drive(4'b1110, 7'h4F, 10);
        drive(4'hF, 7'h00, 10);
        check("single_drain", 32'(sb.size()), 32'h0);

        // partial frame then reset: it must not count toward the next frame
        drive(4'b1101, 7'h06, 8);
        drive(4'b1011, 7'h5B, 8);
        drive(4'b0111, 7'h4F, 8);
        drive(4'hF, 7'h00, 10);
        check("partial_drain", 32'(sb.size()), 32'h0);
        do_reset();

        // full frame 5,0,9,2 then re-capture of digit 0
        drive(4'b1110, 7'h6D, 8);
        drive(4'b1101, 7'h3F, 8);
        drive(4'b1011, 7'h6F, 8);
        drive(4'b0111, 7'h5B, 8);
        drive(4'b1110, 7'h07, 8);
        drive(4'hF, 7'h00, 12);
        check("frame_value", 32'(value), 32'h2907);
        check("frame_digit_valid", 32'(digit_valid), 32'hF);
        check("frame_drain", 32'(sb.size()), 32'h0);
`ifdef SCAN_TIMEOUT_EN
        m_dv = 4'h0; m_seen = 4'h0; m_stale = 1'b1;
        push_ev(m_acc_cyc + TMO, 1'b0);
        drive(4'hF, 7'h00, TMO);
        check("timeout_stale", 32'(stale), 32'h1);
        check("timeout_value_kept", 32'(value), 32'h2907);
        drive(4'b1101, 7'h06, 8);
        drive(4'hF, 7'h00, 10);
        check("timeout_cleared", 32'(stale), 32'h0);
        check("timeout_drain", 32'(sb.size()), 32'h0);
`endif
        do_reset();

        // glitch rejection on digit 1, then a hold of exactly STABLE on digit 2
        drive(4'b1101, 7'h06, 3);
        drive(4'b1101, 7'h5B, 3);
        drive(4'b1101, 7'h06, 5);
        drive(4'b1011, 7'h66, STABLE);
        drive(4'hF, 7'h00, 10);
        check("glitch_value", 32'(value), 32'h0410);
        check("glitch_drain", 32'(sb.size()), 32'h0);
        do_reset();

        // ghosting, then blank pattern on digit 2
        drive(4'b1100, 7'h7F, 20);
        check("ghost_dec_err", 32'(dec_err), 32'h0);
        check("ghost_state", 32'(dut.state), 32'h0);
        check("ghost_value", 32'(value), 32'h0);
        drive(4'b1011, 7'h00, 6);
        drive(4'hF, 7'h00, 6);
        check("bad_dec_err", 32'(dec_err), 32'h1);
        check("bad_nibble2", 32'(value[11:8]), 32'h0);
        check("bad_drain", 32'(sb.size()), 32'h0);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
